la_mux_arb: RTL and testbench

- Parametrised N-channel, W-bit arbitrated multiplexer; the sequential successor to the fixed 3-input combinational mux cell.
- Selection comes from an internal arbiter (round-robin or fixed priority), not from external select lines.
- Each channel has a valid/ready handshake; the winning channel's word is captured into one output register stage.
- Used wherever several producers share one consumer path, e.g. request merging ahead of a bus port.

---
 rtl/la_mux_arb_pkg.sv | 25 ++
 rtl/la_mux_arb_arbiter.sv | 42 ++++
 rtl/la_mux_arb.sv | 108 ++++++++++
 tb/tb_la_mux_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/la_mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// la_mux_arb_pkg
// Shared constants and helpers for the arbitrated multiplexer family.
//   MODE_RR / MODE_PRIO : arbitration mode strings accepted by MODE parameters
//   clog2()             : ceiling log2 for elaboration-time widths
//   sel_width()         : width of a channel index, never narrower than 1 bit
// ---------------------------------------------------------------------------
package la_mux_arb_pkg;

   localparam string MODE_RR   = "RR";
   localparam string MODE_PRIO = "PRIO";

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // A single channel still needs a 1-bit index port.
   function automatic int sel_width(input int n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/la_mux_arb_arbiter.sv
// ---------------------------------------------------------------------------
// la_arbiter
// Combinational one-hot arbiter, reusable by any arbitrated cell.
//   req   [N]  : request vector
//   ptr   [PW] : round-robin start index (ignored in PRIO mode)
//   en         : when low, no grant is issued
//   grant [N]  : one-hot winner, all-zero when no request or en low
// ---------------------------------------------------------------------------
module la_arbiter
   import la_mux_arb_pkg::*;
#(
   parameter int    N    = 4,
   parameter string MODE = "RR",
   parameter int    PW   = sel_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  grant
);

   localparam bit IS_PRIO = (MODE == MODE_PRIO);

   logic [N-1:0]   mask;
   logic [2*N-1:0] dbl;
   logic [2*N-1:0] lowest;

   // Double-width masked find: the low half holds only requests at or above
   // ptr, the high half holds all requests. The lowest set bit of the
   // concatenation is the first request searching upward from ptr with wrap.
   // In PRIO mode the mask is all ones, so the low half alone decides.
   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = IS_PRIO || (i >= int'(ptr));
      end
      dbl    = {req, req & mask};
      lowest = dbl & (~dbl + 1'b1);
      grant  = en ? (lowest[N-1:0] | lowest[2*N-1:N]) : '0;
   end

endmodule

// File: rtl/la_mux_arb.sv
// ---------------------------------------------------------------------------
// la_mux_arb
// N-channel, W-bit arbitrated multiplexer with one output register stage.
//   clk       : clock, rising edge
//   nreset    : asynchronous active-low reset
//   in_valid  [N]   : per-channel valid
//   in_data   [N*W] : channel i at bits [i*W +: W]
//   in_ready  [N]   : per-channel ready, at most one bit high
//   out_valid       : output register holds a word
//   out_data  [W]   : registered data
//   out_sel   [SW]  : channel that supplied out_data
//   out_ready       : downstream accepts out_data
// ---------------------------------------------------------------------------
module la_mux_arb
   import la_mux_arb_pkg::*;
#(
   parameter int    N    = 4,
   parameter int    W    = 32,
   parameter string MODE = "RR",
   parameter string PROP = "DEFAULT",
   localparam int   SW   = sel_width(N)
) (
   input  logic           clk,
   input  logic           nreset,
   input  logic [N-1:0]   in_valid,
   input  logic [N*W-1:0] in_data,
   output logic [N-1:0]   in_ready,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_sel,
   input  logic           out_ready
);

   localparam bit IS_PRIO = (MODE == MODE_PRIO);

   logic          load;
   logic          en;
   logic [N-1:0]  grant;
   logic [SW-1:0] ptr;
   logic [SW-1:0] sel_next;
   logic [W-1:0]  data_next;
   logic          transfer;

   // The register takes a new word when empty or being drained. Gating with
   // nreset keeps every in_ready low while the cell is held in reset.
   assign load = ~out_valid | out_ready;
   assign en   = load & nreset;

   la_arbiter #(
      .N    (N),
      .MODE (MODE),
      .PW   (SW)
   ) u_arb (
      .req   (in_valid),
      .ptr   (ptr),
      .en    (en),
      .grant (grant)
   );

   // grant is a subset of in_valid, so any grant bit is a transfer.
   assign in_ready = grant;
   assign transfer = |grant;

   // One-hot AND-OR select of the winning word and its index.
   always_comb begin
      sel_next  = '0;
      data_next = '0;
      for (int i = 0; i < N; i++) begin
         data_next = data_next | (in_data[i*W +: W] & {W{grant[i]}});
         if (grant[i]) sel_next = sel_next | SW'(i);
      end
   end

   // Output stage: reload on transfer, empty on a drain without reload,
   // otherwise hold (which also freezes data and index during a stall).
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (transfer) begin
         out_valid <= 1'b1;
         out_data  <= data_next;
         out_sel   <= sel_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Round-robin pointer exists only when there is something to rotate.
   if (N > 1 && !IS_PRIO) begin : g_ptr
      always_ff @(posedge clk or negedge nreset) begin
         if (!nreset) begin
            ptr <= '0;
         end else if (transfer) begin
            ptr <= (sel_next == SW'(N-1)) ? '0 : sel_next + 1'b1;
         end
      end
   end else begin : g_no_ptr
      assign ptr = '0;
   end

   // PROP is carried for the cell library only; behaviour is identical for
   // every value, so nothing is elaborated from it.
   if (PROP == "") begin : g_prop_unset
   end

endmodule

// File: tb/tb_la_mux_arb.sv
// ---------------------------------------------------------------------------
// tb_la_mux_arb
// Drives one round-robin and one fixed-priority la_mux_arb (N=4, W=32) side
// by side, comparing both against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_la_mux_arb;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int SW = 2;

   logic clk = 1'b0;
   logic nreset;
   logic out_ready;

   // Index 0 is the RR instance, index 1 the PRIO instance.
   logic [1:0][N-1:0]   in_valid;
   logic [1:0][N*W-1:0] in_data;
   logic [1:0][N-1:0]   in_ready;
   logic [1:0]          out_valid;
   logic [1:0][W-1:0]   out_data;
   logic [1:0][SW-1:0]  out_sel;

   // Reference model state, one output register per instance.
   bit             m_valid [2];
   logic [W-1:0]   m_data  [2];
   int             m_sel   [2];
   int             m_ptr;
   logic [N-1:0]   last_xfer [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   la_mux_arb #(.N(N), .W(W), .MODE("RR"), .PROP("DEFAULT")) dut_rr (
      .clk       (clk),
      .nreset    (nreset),
      .in_valid  (in_valid[0]),
      .in_data   (in_data[0]),
      .in_ready  (in_ready[0]),
      .out_valid (out_valid[0]),
      .out_data  (out_data[0]),
      .out_sel   (out_sel[0]),
      .out_ready (out_ready)
   );

   la_mux_arb #(.N(N), .W(W), .MODE("PRIO"), .PROP("DEFAULT")) dut_prio (
      .clk       (clk),
      .nreset    (nreset),
      .in_valid  (in_valid[1]),
      .in_data   (in_data[1]),
      .in_ready  (in_ready[1]),
      .out_valid (out_valid[1]),
      .out_data  (out_data[1]),
      .out_sel   (out_sel[1]),
      .out_ready (out_ready)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic string devName(input int d);
      return (d == 0) ? "rr" : "prio";
   endfunction

   // Winner by rule: first valid channel searching upward from the start
   // index (RR pointer, or 0 for priority) with wrap-around; -1 if none.
   function automatic int modelWinner(input int d);
      int base;
      int idx;
      base = (d == 0) ? m_ptr : 0;
      for (int k = 0; k < N; k++) begin
         idx = (base + k) % N;
         if (in_valid[d][idx]) return idx;
      end
      return -1;
   endfunction

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         m_valid[d]   = 1'b0;
         m_data[d]    = '0;
         m_sel[d]     = 0;
         last_xfer[d] = '0;
      end
      m_ptr = 0;
   endtask

   task automatic setInputs(input int d, input logic [N-1:0] valid, input logic [W-1:0] base);
      in_valid[d] = valid;
      for (int i = 0; i < N; i++) in_data[d][i*W +: W] = base + W'(i);
   endtask

   // Random inputs that keep each pending word stable until it transfers.
   task automatic applyStimulus();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < N; i++) begin
            if (!in_valid[d][i] || last_xfer[d][i]) begin
               in_valid[d][i]        = ($urandom_range(0, 99) < 55);
               in_data[d][i*W +: W]  = $urandom;
            end
         end
      end
      out_ready = ($urandom_range(0, 99) < 70);
   endtask

   // Entered just after a falling edge with inputs settled; checks in_ready,
   // crosses one rising edge, checks the register, returns on the next fall.
   task automatic stepCycle();
      int           win [2];
      logic [N-1:0] exp_rdy [2];
      bit           ld;
      #1;
      for (int d = 0; d < 2; d++) begin
         ld         = !m_valid[d] || out_ready;
         win[d]     = modelWinner(d);
         exp_rdy[d] = '0;
         if (nreset && ld && win[d] >= 0) exp_rdy[d][win[d]] = 1'b1;
         checkOutput({devName(d), "_in_ready"}, 64'(in_ready[d]), 64'(exp_rdy[d]));
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         last_xfer[d] = exp_rdy[d];
         if (!nreset) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_sel[d]   = 0;
            if (d == 0) m_ptr = 0;
         end else if (exp_rdy[d] != '0) begin
            m_valid[d] = 1'b1;
            m_data[d]  = in_data[d][win[d]*W +: W];
            m_sel[d]   = win[d];
            if (d == 0) m_ptr = (win[d] + 1) % N;
         end else if (out_ready) begin
            m_valid[d] = 1'b0;
         end
         checkOutput({devName(d), "_out_valid"}, 64'(out_valid[d]), 64'(m_valid[d]));
         checkOutput({devName(d), "_out_data"},  64'(out_data[d]),  64'(m_data[d]));
         checkOutput({devName(d), "_out_sel"},   64'(out_sel[d]),   64'(m_sel[d]));
      end
      @(negedge clk);
   endtask

   initial begin
      modelReset();
      nreset    = 1'b0;
      out_ready = 1'b1;
      setInputs(0, 4'b1111, 32'hA0);
      setInputs(1, 4'b1111, 32'hA0);

      // Reset held with every channel valid.
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checkOutput("reset_out_valid", 64'(out_valid[d]), 64'd0);
         checkOutput("reset_out_data",  64'(out_data[d]),  64'd0);
         checkOutput("reset_out_sel",   64'(out_sel[d]),   64'd0);
         checkOutput("reset_in_ready",  64'(in_ready[d]),  64'd0);
      end
      stepCycle();
      stepCycle();

      // RR fairness on one DUT, priority starvation on the other.
      nreset = 1'b1;
      setInputs(1, 4'b1010, 32'hC0);
      for (int k = 0; k < 8; k++) begin
         stepCycle();
         checkOutput("fair_sel",   64'(out_sel[0]),   64'(k % N));
         checkOutput("fair_data",  64'(out_data[0]),  64'(32'hA0 + k % N));
         checkOutput("fair_valid", 64'(out_valid[0]), 64'd1);
         checkOutput("prio_sel",   64'(out_sel[1]),   64'd1);
      end
      setInputs(1, 4'b1000, 32'hC0);
      stepCycle();
      checkOutput("prio_ch3_sel",  64'(out_sel[1]),  64'd3);
      checkOutput("prio_ch3_data", 64'(out_data[1]), 64'hC3);

      // Sparse requests with wrap-around of the RR pointer.
      setInputs(0, 4'b0100, 32'hA0);
      stepCycle();
      checkOutput("sparse_sel_a", 64'(out_sel[0]), 64'd2);
      setInputs(0, 4'b0010, 32'hA0);
      stepCycle();
      checkOutput("sparse_wrap_sel", 64'(out_sel[0]), 64'd1);
      setInputs(0, 4'b0101, 32'hA0);
      stepCycle();
      checkOutput("sparse_next_sel", 64'(out_sel[0]), 64'd2);

      // Backpressure after a ch2 load, then drain and reload together.
      setInputs(0, 4'b0100, 32'hB0);
      stepCycle();
      out_ready = 1'b0;
      setInputs(0, 4'b1111, 32'hD0);
      for (int k = 0; k < 5; k++) begin
         stepCycle();
         checkOutput("bp_sel",      64'(out_sel[0]),  64'd2);
         checkOutput("bp_data",     64'(out_data[0]), 64'hB2);
         checkOutput("bp_in_ready", 64'(in_ready[0]), 64'd0);
      end
      out_ready = 1'b1;
      stepCycle();
      checkOutput("bp_reload_valid", 64'(out_valid[0]), 64'd1);
      checkOutput("bp_reload_sel",   64'(out_sel[0]),   64'd3);
      checkOutput("bp_reload_data",  64'(out_data[0]),  64'hD3);

      // Asynchronous reset between edges while a word is held.
      #2;
      nreset = 1'b0;
      #1;
      checkOutput("async_rr_valid",   64'(out_valid[0]), 64'd0);
      checkOutput("async_prio_valid", 64'(out_valid[1]), 64'd0);
      checkOutput("async_rr_data",    64'(out_data[0]),  64'd0);
      modelReset();
      @(negedge clk);
      stepCycle();
      nreset = 1'b1;
      setInputs(0, 4'b1111, 32'hE0);
      stepCycle();
      checkOutput("restart_sel",  64'(out_sel[0]),  64'd0);
      checkOutput("restart_data", 64'(out_data[0]), 64'hE0);

      // Randomised traffic with random backpressure.
      for (int k = 0; k < 400; k++) begin
         applyStimulus();
         stepCycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
